// File: rtl/fpcmult_seq.sv
// Sequential fixed-point complex multiplier.
// Three real products (Gauss/Karatsuba form) are computed one after another
// on a single radix-2 signed shift-add multiplier, then the two results are
// rounded (half toward +inf) and either saturated or wrapped to N bits.
module fpcmult_seq #(
    parameter int N   = 32,
    parameter int D   = 16,
    parameter int SAT = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         recv_val,
    output logic         recv_rdy,
    input  logic [N-1:0] ar,
    input  logic [N-1:0] ac,
    input  logic [N-1:0] br,
    input  logic [N-1:0] bc,
    input  logic         conj,
    output logic         send_val,
    input  logic         send_rdy,
    output logic [N-1:0] cr,
    output logic [N-1:0] cc,
    output logic         ovf
);
    localparam int M  = N + 2;        // multiplier operand width
    localparam int W  = 2 * N + 4;    // full-precision product width
    localparam int CW = $clog2(M);
    localparam logic [W-1:0] HALF = W'(1) << (D - 1);

    typedef enum logic [2:0] {IDLE, MUL1, MUL2, MUL3, FIN, DONE} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   acc_q, acc_d;     // running product; holds p3 in FIN
    logic [W-1:0]   mc_q, mc_d;       // multiplicand, shifted left each step
    logic [M-1:0]   mp_q, mp_d;       // multiplier, shifted right each step
    logic [W-1:0]   p1_q, p1_d;
    logic [W-1:0]   p2_q, p2_d;
    logic [N-1:0]   ar_q, ar_d, ac_q, ac_d, br_q, br_d;
    logic [N:0]     bcp_q, bcp_d;     // bc or -bc, one extra bit so -MIN is exact
    logic [N-1:0]   cr_q, cr_d, cc_q, cc_d;
    logic           ovf_q, ovf_d;

    // Round half toward +inf, then clamp or wrap; MSB of result is overflow flag.
    function automatic logic [N:0] rnd_sat(input logic [W-1:0] raw);
        logic [W-1:0] r;
        logic         fits;
        r    = $signed(raw + HALF) >>> D;
        fits = (&r[W-1:N-1]) | ~(|r[W-1:N-1]);
        if (fits)          return {1'b0, r[N-1:0]};
        else if (SAT != 0) return {1'b1, r[W-1], {(N-1){~r[W-1]}}};
        else               return {1'b1, r[N-1:0]};
    endfunction

    logic [N:0]   bc_ext, bcp_in;
    logic [M-1:0] sa, sb;
    logic [W-1:0] pp, acc_step, raw_r, raw_c;
    logic [N:0]   res_r, res_c;
    logic         last;

    // Next-state, multiplier datapath and result formatting.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mc_d    = mc_q;
        mp_d    = mp_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        ar_d    = ar_q;
        ac_d    = ac_q;
        br_d    = br_q;
        bcp_d   = bcp_q;
        cr_d    = cr_q;
        cc_d    = cc_q;
        ovf_d   = ovf_q;

        bc_ext   = {bc[N-1], bc};
        bcp_in   = conj ? (~bc_ext + 1'b1) : bc_ext;
        sa       = {{2{ar_q[N-1]}}, ar_q} + {{2{ac_q[N-1]}}, ac_q};
        sb       = {{2{br_q[N-1]}}, br_q} + {bcp_q[N], bcp_q};
        pp       = mp_q[0] ? mc_q : '0;
        last     = (cnt_q == CW'(M - 1));
        // Top multiplier bit carries negative weight in two's complement.
        acc_step = last ? (acc_q - pp) : (acc_q + pp);
        raw_r    = p1_q - p2_q;
        raw_c    = acc_q - p1_q - p2_q;
        res_r    = rnd_sat(raw_r);
        res_c    = rnd_sat(raw_c);

        case (state_q)
            IDLE: begin
                if (recv_val) begin
                    ar_d    = ar;
                    ac_d    = ac;
                    br_d    = br;
                    bcp_d   = bcp_in;
                    mc_d    = {{(W-N){ar[N-1]}}, ar};
                    mp_d    = {{2{br[N-1]}}, br};
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = MUL1;
                end
            end
            MUL1, MUL2, MUL3: begin
                acc_d = acc_step;
                mc_d  = mc_q << 1;
                mp_d  = mp_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (last) begin
                    cnt_d = '0;
                    if (state_q == MUL1) begin
                        p1_d    = acc_step;
                        acc_d   = '0;
                        mc_d    = {{(W-N){ac_q[N-1]}}, ac_q};
                        mp_d    = {bcp_q[N], bcp_q};
                        state_d = MUL2;
                    end else if (state_q == MUL2) begin
                        p2_d    = acc_step;
                        acc_d   = '0;
                        mc_d    = {{(W-M){sa[M-1]}}, sa};
                        mp_d    = sb;
                        state_d = MUL3;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            FIN: begin
                cr_d    = res_r[N-1:0];
                cc_d    = res_c[N-1:0];
                ovf_d   = res_r[N] | res_c[N];
                state_d = DONE;
            end
            DONE: begin
                if (send_rdy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mc_q    <= '0;
            mp_q    <= '0;
            p1_q    <= '0;
            p2_q    <= '0;
            ar_q    <= '0;
            ac_q    <= '0;
            br_q    <= '0;
            bcp_q   <= '0;
            cr_q    <= '0;
            cc_q    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mc_q    <= mc_d;
            mp_q    <= mp_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            ar_q    <= ar_d;
            ac_q    <= ac_d;
            br_q    <= br_d;
            bcp_q   <= bcp_d;
            cr_q    <= cr_d;
            cc_q    <= cc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign recv_rdy = (state_q == IDLE);
    assign send_val = (state_q == DONE);
    assign cr       = cr_q;
    assign cc       = cc_q;
    assign ovf      = ovf_q;
endmodule

// File: tb/tb_fpcmult_seq.sv
// Directed test of fpcmult_seq (N=32, D=16): one SAT=1 and one SAT=0 instance
// share all inputs and run in lockstep.
module tb_fpcmult_seq;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        recv_val = 1'b0;
    logic        send_rdy = 1'b0;
    logic        conj = 1'b0;
    logic [31:0] ar = '0, ac = '0, br = '0, bc = '0;
    logic        recv_rdy, send_val, ovf;
    logic [31:0] cr, cc;
    logic        recv_rdy_w, send_val_w, ovf_w;
    logic [31:0] cr_w, cc_w;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fpcmult_seq #(.N(32), .D(16), .SAT(1)) dut (
        .clk(clk), .reset(reset), .recv_val(recv_val), .recv_rdy(recv_rdy),
        .ar(ar), .ac(ac), .br(br), .bc(bc), .conj(conj),
        .send_val(send_val), .send_rdy(send_rdy), .cr(cr), .cc(cc), .ovf(ovf)
    );

    fpcmult_seq #(.N(32), .D(16), .SAT(0)) dut_w (
        .clk(clk), .reset(reset), .recv_val(recv_val), .recv_rdy(recv_rdy_w),
        .ar(ar), .ac(ac), .br(br), .bc(bc), .conj(conj),
        .send_val(send_val_w), .send_rdy(send_rdy), .cr(cr_w), .cc(cc_w), .ovf(ovf_w)
    );

    // Present one operand set, then count edges from accept until send_val.
    task automatic run_op(input logic [31:0] a_r, a_c, b_r, b_c, input logic cj,
                          output int lat);
        @(negedge clk);
        ar = a_r; ac = a_c; br = b_r; bc = b_c; conj = cj; recv_val = 1'b1;
        @(posedge clk);
        #1;
        recv_val = 1'b0;
        ar = 32'hDEAD_BEEF; ac = 32'h1234_5678; br = 32'h8000_0000; bc = 32'hFFFF_FFFF;
        conj = ~cj;
        lat = 0;
        while (!send_val && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic handshake;
        @(negedge clk);
        send_rdy = 1'b1;
        @(posedge clk);
        #1;
        send_rdy = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        #2;
        tests++;
        if (recv_rdy !== 1'b1 || send_val !== 1'b0 || cr !== 32'h0 || cc !== 32'h0 || ovf !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: rdy=%b val=%b cr=%h cc=%h ovf=%b, want 1 0 0 0 0",
                     recv_rdy, send_val, cr, cc, ovf);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_basic;
        int lat;
        run_op(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000, 1'b0, lat);
        tests++;
        if (lat !== 103) begin fails++; $display("FAIL basic_latency: got %0d want 103", lat); end
        tests++;
        if (cr !== 32'hFFFB_0000 || cc !== 32'h000A_0000 || ovf !== 1'b0) begin
            fails++;
            $display("FAIL basic_result: cr=%h cc=%h ovf=%b want fffb0000 000a0000 0", cr, cc, ovf);
        end
        handshake();
        tests++;
        if (recv_rdy !== 1'b1 || send_val !== 1'b0) begin
            fails++;
            $display("FAIL basic_return_idle: rdy=%b val=%b want 1 0", recv_rdy, send_val);
        end
        tests++;
        if (cr !== 32'hFFFB_0000 || cc !== 32'h000A_0000) begin
            fails++;
            $display("FAIL basic_hold: cr=%h cc=%h want fffb0000 000a0000", cr, cc);
        end
    endtask

    task automatic test_conj;
        int lat;
        run_op(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000, 1'b1, lat);
        tests++;
        if (lat !== 103 || cr !== 32'h000B_0000 || cc !== 32'h0002_0000 || ovf !== 1'b0) begin
            fails++;
            $display("FAIL conj_result: lat=%0d cr=%h cc=%h ovf=%b want 103 000b0000 00020000 0",
                     lat, cr, cc, ovf);
        end
        handshake();
    endtask

    task automatic test_sat;
        int lat;
        run_op(32'h7FFF_0000, 32'h0, 32'h0002_0000, 32'h0, 1'b0, lat);
        tests++;
        if (cr !== 32'h7FFF_FFFF || cc !== 32'h0 || ovf !== 1'b1) begin
            fails++;
            $display("FAIL sat_clamp: cr=%h cc=%h ovf=%b want 7fffffff 0 1", cr, cc, ovf);
        end
        tests++;
        if (send_val_w !== 1'b1 || cr_w !== 32'hFFFE_0000 || cc_w !== 32'h0 || ovf_w !== 1'b1) begin
            fails++;
            $display("FAIL wrap_trunc: val=%b cr=%h cc=%h ovf=%b want 1 fffe0000 0 1",
                     send_val_w, cr_w, cc_w, ovf_w);
        end
        handshake();
        // Negative clamp: -32768 * 2 -> -65536
        run_op(32'h8000_0000, 32'h0, 32'h0002_0000, 32'h0, 1'b0, lat);
        tests++;
        if (cr !== 32'h8000_0000 || ovf !== 1'b1 || cr_w !== 32'h0000_0000) begin
            fails++;
            $display("FAIL sat_neg: cr=%h ovf=%b cr_w=%h want 80000000 1 00000000", cr, ovf, cr_w);
        end
        handshake();
    endtask

    task automatic test_round;
        int lat;
        run_op(32'h0000_0001, 32'h0, 32'h0000_8000, 32'h0, 1'b0, lat);
        tests++;
        if (cr !== 32'h0000_0001 || ovf !== 1'b0) begin
            fails++;
            $display("FAIL round_pos_half: cr=%h ovf=%b want 00000001 0", cr, ovf);
        end
        handshake();
        run_op(32'hFFFF_FFFF, 32'h0, 32'h0000_8000, 32'h0, 1'b0, lat);
        tests++;
        if (cr !== 32'h0000_0000 || cc !== 32'h0 || ovf !== 1'b0) begin
            fails++;
            $display("FAIL round_neg_half: cr=%h cc=%h ovf=%b want 0 0 0", cr, cc, ovf);
        end
        handshake();
    endtask

    task automatic test_backpressure;
        int lat;
        int bad = 0;
        run_op(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000, 1'b0, lat);
        @(negedge clk);
        recv_val = 1'b1;
        ar = 32'h0005_0000;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (send_val !== 1'b1 || recv_rdy !== 1'b0 ||
                cr !== 32'hFFFB_0000 || cc !== 32'h000A_0000) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL backpressure_hold: %0d unstable cycles, val=%b rdy=%b cr=%h cc=%h",
                     bad, send_val, recv_rdy, cr, cc);
        end
        recv_val = 1'b0;
        handshake();
        tests++;
        if (recv_rdy !== 1'b1 || send_val !== 1'b0) begin
            fails++;
            $display("FAIL backpressure_release: rdy=%b val=%b want 1 0", recv_rdy, send_val);
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        int seen = 0;
        @(negedge clk);
        ar = 32'h0001_0000; ac = 32'h0002_0000; br = 32'h0003_0000; bc = 32'h0004_0000;
        conj = 1'b1; recv_val = 1'b1;
        @(posedge clk);
        #1;
        recv_val = 1'b0;
        repeat (50) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        tests++;
        if (cr !== 32'h0 || cc !== 32'h0 || ovf !== 1'b0 || send_val !== 1'b0 || recv_rdy !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_clear: cr=%h cc=%h ovf=%b val=%b rdy=%b want 0 0 0 0 1",
                     cr, cc, ovf, send_val, recv_rdy);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 120; i++) begin
            @(posedge clk);
            #1;
            if (send_val) seen++;
        end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL reset_mid_no_result: send_val seen %0d cycles, want 0", seen);
        end
        run_op(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000, 1'b0, lat);
        tests++;
        if (lat !== 103 || cr !== 32'hFFFB_0000 || cc !== 32'h000A_0000 || ovf !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_fresh: lat=%0d cr=%h cc=%h ovf=%b want 103 fffb0000 000a0000 0",
                     lat, cr, cc, ovf);
        end
        handshake();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_conj();
        test_sat();
        test_round();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
